snes_dejitter_gen: RTL and testbench

SNES_DEJITTER_GEN -- requirements
Module: snes_dejitter_gen

---
 rtl/snes_dejitter_gen.sv | 157 +++++++++++++++
 tb/tb_snes_dejitter_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/snes_dejitter_gen.sv
// Dejitters SNES composite sync by gating GATE_CYCLES master clocks on every
// short (1360) line once line timing is locked, and divides MCLK into SC_o.
//
// state    | meaning
// ---------+----------------------------------------------------------
// UNLOCKED | counting consecutive valid lines toward LOCK_LINES
// LOCKED   | line timing trusted; short lines are compensated
module snes_dejitter_gen #(
  parameter int LONG_LEN    = 1364,
  parameter int SHORT_LEN   = 1360,
  parameter int H_MIN       = 1024,
  parameter int GATE_CYCLES = 4,
  parameter int LOCK_LINES  = 8,
  parameter int SC_DIV      = 3,
  parameter int CNT_W       = 11
) (
  input  logic             MCLK_i,
  input  logic             RST_i,
  input  logic             BYPASS_i,
  input  logic             CSYNC_i,
  output logic             CSYNC_o,
  output logic             GCLK_EN_o,
  output logic             SC_o,
  output logic             LOCKED_o,
  output logic             SHORT_LINE_o,
  output logic [CNT_W-1:0] LINE_LEN_o
);

  localparam logic [CNT_W-1:0] H_MAX     = '1;
  localparam logic [CNT_W-1:0] H_MIN_C   = CNT_W'(H_MIN);
  localparam logic [CNT_W-1:0] LONG_END  = CNT_W'(LONG_LEN - 1);
  localparam logic [CNT_W-1:0] SHORT_END = CNT_W'(SHORT_LEN - 1);
  localparam int               LC_W      = $clog2(LOCK_LINES + 1);
  localparam logic [LC_W-1:0]  LOCK_C    = LC_W'(LOCK_LINES);
  localparam int               SC_W      = (SC_DIV > 1) ? $clog2(SC_DIV) : 1;
  localparam logic [SC_W-1:0]  SC_LAST   = SC_W'(SC_DIV - 1);
  localparam logic [2:0]       GATE_C    = 3'(GATE_CYCLES);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  lock_state_t      state, state_nxt;
  logic [LC_W-1:0]  lock_cnt, lock_cnt_nxt;
  logic [CNT_W-1:0] h_cnt;
  logic [2:0]       g_cyc;
  logic [SC_W-1:0]  sc_ctr;
  logic             csync_prev;
  logic             csync_q;
  logic             gclk_en_q;
  logic             sc_q;
  logic             short_q;
  logic             sync_fall;
  logic             line_start;
  logic             line_valid;
  logic             h_sat;
  logic             comp_trig;
  logic             gate_hold;

  // Falling edges early in the line are equalisation/serration pulses.
  assign sync_fall  = csync_prev & ~CSYNC_i;
  assign line_start = sync_fall & (h_cnt >= H_MIN_C);
  assign line_valid = (h_cnt == LONG_END) | (h_cnt == SHORT_END);
  assign h_sat      = (h_cnt == H_MAX);
  assign comp_trig  = line_start & (h_cnt == SHORT_END) & (state == LOCKED) & ~BYPASS_i;
  assign gate_hold  = (g_cyc > 3'd1);

  assign CSYNC_o      = BYPASS_i ? CSYNC_i : csync_q;
  assign GCLK_EN_o    = gclk_en_q;
  assign SC_o         = sc_q;
  assign LOCKED_o     = (state == LOCKED);
  assign SHORT_LINE_o = short_q;

  always_ff @(posedge MCLK_i) begin
    if (RST_i) begin
      csync_prev <= 1'b1;
      h_cnt      <= '0;
      LINE_LEN_o <= '0;
    end else begin
      csync_prev <= CSYNC_i;
      if (line_start) begin
        h_cnt      <= '0;
        LINE_LEN_o <= h_cnt;
      end else if (!h_sat) begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge MCLK_i) begin
    if (RST_i) begin
      state    <= UNLOCKED;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    if (state == UNLOCKED) begin
      if (line_start) begin
        if (line_valid) begin
          lock_cnt_nxt = lock_cnt + LC_W'(1);
          if (lock_cnt_nxt == LOCK_C) begin
            state_nxt = LOCKED;
          end
        end else begin
          lock_cnt_nxt = '0;
        end
      end
    end else begin
      if ((line_start && !line_valid) || h_sat) begin
        state_nxt    = UNLOCKED;
        lock_cnt_nxt = '0;
      end
    end
  end

  // The output sync is frozen while the gate is open so its falling edge
  // slips by exactly the number of swallowed MCLK cycles.
  always_ff @(posedge MCLK_i) begin
    if (RST_i) begin
      g_cyc     <= 3'd0;
      csync_q   <= 1'b1;
      gclk_en_q <= 1'b1;
      short_q   <= 1'b0;
    end else begin
      short_q   <= comp_trig;
      gclk_en_q <= (g_cyc == 3'd0) | BYPASS_i;
      if (comp_trig) begin
        g_cyc <= GATE_C;
      end else if (g_cyc != 3'd0) begin
        g_cyc <= g_cyc - 3'd1;
      end
      if (!comp_trig && !gate_hold) begin
        csync_q <= CSYNC_i;
      end
    end
  end

  always_ff @(posedge MCLK_i) begin
    if (RST_i) begin
      sc_ctr <= '0;
      sc_q   <= 1'b0;
    end else if (sc_ctr == SC_LAST) begin
      sc_ctr <= '0;
      sc_q   <= ~sc_q;
    end else begin
      sc_ctr <= sc_ctr + SC_W'(1);
    end
  end

endmodule

// File: tb/tb_snes_dejitter_gen.sv
// Self-checking bench for snes_dejitter_gen: directed line scenarios plus
// randomized lines, all cycles compared against a behavioural line model.
module tb_snes_dejitter_gen;

  logic        MCLK_i   = 1'b0;
  logic        RST_i    = 1'b1;
  logic        BYPASS_i = 1'b0;
  logic        CSYNC_i  = 1'b1;
  logic        CSYNC_o;
  logic        GCLK_EN_o;
  logic        SC_o;
  logic        LOCKED_o;
  logic        SHORT_LINE_o;
  logic [10:0] LINE_LEN_o;

  int n_tests = 0;
  int n_fail  = 0;

  snes_dejitter_gen #(
    .LONG_LEN(1364), .SHORT_LEN(1360), .H_MIN(1024), .GATE_CYCLES(4),
    .LOCK_LINES(8), .SC_DIV(3), .CNT_W(11)
  ) dut (
    .MCLK_i(MCLK_i), .RST_i(RST_i), .BYPASS_i(BYPASS_i), .CSYNC_i(CSYNC_i),
    .CSYNC_o(CSYNC_o), .GCLK_EN_o(GCLK_EN_o), .SC_o(SC_o), .LOCKED_o(LOCKED_o),
    .SHORT_LINE_o(SHORT_LINE_o), .LINE_LEN_o(LINE_LEN_o)
  );

  always #5 MCLK_i = ~MCLK_i;

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line-level model: cycles since line start, valid-line run, lock flag,
  // and the cycle index of the last compensation trigger.
  int m_hc, m_run, m_n, m_tt, m_len;
  bit m_locked, m_prev, m_outq, m_short, m_gclk;

  task automatic model_update();
    bit fall, ls, valid, trig, in_gate;
    if (RST_i) begin
      m_hc = 0; m_run = 0; m_n = 0; m_tt = -1000; m_len = 0;
      m_locked = 0; m_prev = 1; m_outq = 1; m_short = 0; m_gclk = 1;
    end else begin
      m_n++;
      fall    = m_prev && !CSYNC_i;
      ls      = fall && (m_hc >= 1024);
      valid   = (m_hc == 1363) || (m_hc == 1359);
      trig    = ls && (m_hc == 1359) && m_locked && !BYPASS_i;
      in_gate = (m_n - m_tt >= 1) && (m_n - m_tt <= 4);
      m_gclk  = BYPASS_i || !in_gate;
      if (!trig && !((m_n - m_tt >= 1) && (m_n - m_tt <= 3))) m_outq = CSYNC_i;
      if (trig) m_tt = m_n;
      m_short = trig;
      if (ls) begin
        m_len = m_hc;
        if (m_locked) begin
          if (!valid) begin m_locked = 0; m_run = 0; end
        end else if (valid) begin
          m_run++;
          if (m_run == 8) m_locked = 1;
        end else begin
          m_run = 0;
        end
      end else if (m_locked && m_hc == 2047) begin
        m_locked = 0; m_run = 0;
      end
      m_hc   = ls ? 0 : ((m_hc < 2047) ? m_hc + 1 : 2047);
      m_prev = CSYNC_i;
    end
  endtask

  task automatic step();
    logic [15:0] obs, exp;
    model_update();
    @(posedge MCLK_i);
    #1;
    obs = {CSYNC_o, GCLK_EN_o, SC_o, LOCKED_o, SHORT_LINE_o, LINE_LEN_o};
    exp = {(BYPASS_i ? CSYNC_i : m_outq), m_gclk, 1'((m_n / 3) % 2), m_locked,
           m_short, 11'(m_len)};
    chk("outs", 32'(obs), 32'(exp));
  endtask

  int st_low, st_short, st_lag, st_bmis;

  // One line: falling edge lands on the first step, so line start spacing is len.
  task automatic do_line(input int len, input bit byp, input bit serr, input int flip_at);
    st_low = 0; st_short = 0; st_lag = -1; st_bmis = 0;
    BYPASS_i = byp;
    CSYNC_i  = 1'b0;
    for (int k = 1; k <= len; k++) begin
      step();
      if (!GCLK_EN_o) st_low++;
      if (SHORT_LINE_o) st_short++;
      if (st_lag < 0 && !CSYNC_o) st_lag = k;
      if (CSYNC_o !== CSYNC_i) st_bmis++;
      if (k == 100) CSYNC_i = 1'b1;
      if (serr && k == 601) CSYNC_i = 1'b0;
      if (serr && k == 631) CSYNC_i = 1'b1;
      if (k == flip_at) BYPASS_i = ~BYPASS_i;
    end
  endtask

  initial begin
    int tot_low, tot_short, sc_prev, sc_first, sc_tog, sc_off, fr_low;
    int r, len;
    bit byp, serr;
    int flip;

    repeat (3) step();
    chk("rst_csync", CSYNC_o, 1);
    chk("rst_gclk", GCLK_EN_o, 1);
    chk("rst_sc", SC_o, 0);
    chk("rst_locked", LOCKED_o, 0);
    chk("rst_short", SHORT_LINE_o, 0);
    chk("rst_len", LINE_LEN_o, 0);

    RST_i = 1'b0;
    repeat (1363) step();
    tot_low = 0; tot_short = 0;
    for (int i = 0; i < 7; i++) begin
      do_line(1364, 0, 0, 0);
      tot_low += st_low; tot_short += st_short;
    end
    chk("lock_before_8th", LOCKED_o, 0);
    do_line(1364, 0, 0, 0);
    tot_low += st_low; tot_short += st_short;
    chk("lock_after_8th", LOCKED_o, 1);
    chk("len_long", LINE_LEN_o, 1363);
    chk("lock_gclk_low", tot_low, 0);
    chk("lock_short", tot_short, 0);

    do_line(1360, 0, 0, 0);
    do_line(1364, 0, 0, 0);
    chk("comp_short_pulses", st_short, 1);
    chk("comp_gclk_low", st_low, 4);
    chk("comp_csync_lag", st_lag, 5);
    chk("comp_len", LINE_LEN_o, 1359);
    chk("comp_locked", LOCKED_o, 1);

    do_line(1360, 0, 0, 0);
    do_line(1364, 1, 0, 0);
    chk("byp_short_pulses", st_short, 0);
    chk("byp_gclk_low", st_low, 0);
    chk("byp_csync_mis", st_bmis, 0);
    chk("byp_locked", LOCKED_o, 1);

    do_line(1364, 0, 0, 0);
    do_line(1300, 0, 1, 0);
    chk("serr_len", LINE_LEN_o, 1363);
    chk("serr_locked", LOCKED_o, 1);
    do_line(1364, 0, 0, 0);
    chk("bad_line_unlock", LOCKED_o, 0);
    chk("bad_line_len", LINE_LEN_o, 1299);

    for (int i = 0; i < 8; i++) do_line(1364, 0, 0, 0);
    chk("relock", LOCKED_o, 1);
    do_line(1360, 0, 0, 0);
    BYPASS_i = 1'b0;
    CSYNC_i  = 1'b0;
    step();
    chk("rst_scn_pulse", SHORT_LINE_o, 1);
    step();
    chk("rst_scn_gate1", GCLK_EN_o, 0);
    step();
    chk("rst_scn_gate2", GCLK_EN_o, 0);
    RST_i = 1'b1;
    step();
    RST_i = 1'b0;
    chk("rst_scn_gclk", GCLK_EN_o, 1);
    chk("rst_scn_locked", LOCKED_o, 0);
    chk("rst_scn_csync", CSYNC_o, 1);
    CSYNC_i = 1'b1;

    sc_prev = SC_o; sc_first = -1; sc_tog = 0; sc_off = 0; fr_low = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (SC_o !== 1'(sc_prev)) begin
        sc_tog++;
        if (sc_first < 0) sc_first = k;
        if ((k % 3) != 0) sc_off++;
      end
      sc_prev = SC_o;
      if (!GCLK_EN_o) fr_low++;
    end
    chk("sc_first_toggle", sc_first, 3);
    chk("sc_toggles", sc_tog, 20);
    chk("sc_off_grid", sc_off, 0);
    chk("gate_aborted", fr_low, 0);

    for (int i = 0; i < 10; i++) do_line(1364, 0, 0, 0);
    chk("sat_prelock", LOCKED_o, 1);
    repeat (800) step();
    chk("sat_unlock", LOCKED_o, 0);
    chk("sat_len_hold", LINE_LEN_o, 1363);

    for (int i = 0; i < 15; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) len = 1300;
      else if (r == 1) len = $urandom_range(700, 1500);
      else if (r <= 8) len = 1360;
      else len = 1364;
      byp  = ($urandom_range(0, 5) == 0);
      serr = (len >= 1024) && ($urandom_range(0, 3) == 0);
      flip = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : 0;
      do_line(len, byp, serr, flip);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
